// File: rtl/tmds_pkg.sv
// ============================================================================
//  Module   : tmds_pkg
//  Purpose  : Shared TMDS definitions: symbol width, control tokens,
//             receiver lock-state encoding and a symbol popcount helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tmds_pkg;

  localparam int SYM_W = 10;

  // Control tokens sent during blanking, indexed by {C1,C0}.
  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2
  } tmds_lock_e;

  // Number of ones in a full 10-bit symbol (0..10).
  function automatic logic [3:0] popcount10(input logic [SYM_W-1:0] sym);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < SYM_W; i++) begin
      n = n + {3'b000, sym[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
// ============================================================================
//  Module   : tmds_symbol_decode
//  Purpose  : Combinational TMDS symbol classifier: detects the four control
//             tokens and undoes the transition-minimising data encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] symbol,
  output logic             is_token,
  output logic [1:0]       ctrl,
  output logic [7:0]       data
);

  logic [7:0] d;

  // Undo optional inversion (q[9]) then XOR/XNOR chain (q[8]).
  always_comb begin
    d       = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = symbol[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Token lookup; anything else is a data symbol.
  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (symbol)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       is_token = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tmds_decoder.sv
// ============================================================================
//  Module   : tmds_decoder
//  Purpose  : Per-channel TMDS receive decoder. Two-stage pipeline recovering
//             pixel byte / control bits / blanking, with a control-token lock
//             FSM and an optional running-disparity monitor.
//  Option   : define TMDS_DEC_DISP_CHECK_EN to build the disparity monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int DISP_LIMIT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SYM_W-1:0] i_encoded,
  output logic [7:0]       o_data,
  output logic [1:0]       o_control_data,
  output logic             o_blanking,
  output logic             o_locked,
  output logic             o_err_disparity
);

  // Reject out-of-range configurations at elaboration.
  if (LOCK_COUNT < 2 || LOCK_COUNT > 255) begin : g_bad_lock_count
    $error("tmds_decoder: LOCK_COUNT must be in 2..255");
  end
  if (DISP_LIMIT < 0 || DISP_LIMIT > 30) begin : g_bad_disp_limit
    $error("tmds_decoder: DISP_LIMIT must be in 0..30");
  end

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

  // ---------------------------------------------------------------- stage 1
  logic       dec_is_token;
  logic [1:0] dec_ctrl_c;
  logic [7:0] dec_data_c;

  tmds_symbol_decode u_symbol_decode (
    .symbol   (i_encoded),
    .is_token (dec_is_token),
    .ctrl     (dec_ctrl_c),
    .data     (dec_data_c)
  );

  // s1_valid keeps the flushed pipeline from being seen as a real token.
  logic       s1_valid;
  logic       s1_is_token;
  logic [1:0] s1_ctrl;
  logic [7:0] s1_data;

  // Stage 1: register the classified symbol.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_is_token <= 1'b1;
      s1_ctrl     <= '0;
      s1_data     <= '0;
    end else begin
      s1_valid    <= 1'b1;
      s1_is_token <= dec_is_token;
      s1_ctrl     <= dec_ctrl_c;
      s1_data     <= dec_data_c;
    end
  end

  // ------------------------------------------------------- disparity check
  logic violation;

`ifdef TMDS_DEC_DISP_CHECK_EN
  localparam logic [7:0] DISP_LIMIT_U = 8'(DISP_LIMIT);

  logic [3:0]        s1_ones;
  logic signed [5:0] disp_acc;
  logic signed [7:0] disp_delta;
  logic signed [7:0] disp_sum;
  logic signed [5:0] disp_sat;
  logic [7:0]        disp_mag;
  logic              err_pulse;

  // Stage 1 companion: popcount of the raw symbol.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_ones <= '0;
    end else begin
      s1_ones <= popcount10(i_encoded);
    end
  end

  // Candidate accumulator value, its magnitude and a 6-bit saturated copy.
  always_comb begin
    disp_delta = $signed({3'b000, s1_ones, 1'b0}) - 8'sd10;
    disp_sum   = $signed({{2{disp_acc[5]}}, disp_acc}) + disp_delta;
    disp_mag   = disp_sum[7] ? $unsigned(-disp_sum) : $unsigned(disp_sum);
    if (disp_sum > 8'sd31) begin
      disp_sat = 6'sd31;
    end else if (disp_sum < -8'sd32) begin
      disp_sat = 6'b100000;
    end else begin
      disp_sat = $signed(disp_sum[5:0]);
    end
    violation = s1_valid && !s1_is_token && (disp_mag > DISP_LIMIT_U);
  end

  // Stage 2: accumulator update and error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      disp_acc  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= violation;
      if (s1_valid) begin
        if (s1_is_token || violation) begin
          disp_acc <= '0;
        end else begin
          disp_acc <= disp_sat;
        end
      end
    end
  end

  assign o_err_disparity = err_pulse;
`else
  assign violation       = 1'b0;
  assign o_err_disparity = 1'b0;
`endif

  // ---------------------------------------------------------------- stage 2
  tmds_lock_e lock_state;
  logic [7:0] run_cnt;
  logic [7:0] dec_data;
  logic [1:0] dec_ctrl;
  logic       dec_blank;
  logic       locked;

  // Stage 2: decoded outputs and lock FSM; a violation overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_state <= UNLOCKED;
      run_cnt    <= '0;
      dec_data   <= '0;
      dec_ctrl   <= '0;
      dec_blank  <= 1'b1;
      locked     <= 1'b0;
    end else if (s1_valid) begin
      dec_blank <= s1_is_token;
      if (s1_is_token) begin
        dec_ctrl <= s1_ctrl;
      end else begin
        dec_data <= s1_data;
      end

      if (violation) begin
        lock_state <= UNLOCKED;
        run_cnt    <= '0;
        locked     <= 1'b0;
      end else begin
        case (lock_state)
          UNLOCKED: begin
            if (s1_is_token) begin
              lock_state <= SEARCH;
              run_cnt    <= 8'd1;
            end
          end
          SEARCH: begin
            if (s1_is_token) begin
              if (run_cnt + 8'd1 == LOCK_TARGET) begin
                lock_state <= LOCKED;
                run_cnt    <= '0;
                locked     <= 1'b1;
              end else begin
                run_cnt <= run_cnt + 8'd1;
              end
            end else begin
              lock_state <= UNLOCKED;
              run_cnt    <= '0;
            end
          end
          LOCKED: begin
            locked <= 1'b1;
          end
          default: begin
            lock_state <= UNLOCKED;
            run_cnt    <= '0;
            locked     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_data         = dec_data;
  assign o_control_data = dec_ctrl;
  assign o_blanking     = dec_blank;
  assign o_locked       = locked;

endmodule

`default_nettype wire

// File: tb/tb_tmds_decoder.sv
// ============================================================================
//  Module   : tb_tmds_decoder
//  Purpose  : Scoreboard bench for tmds_decoder: directed scenarios, encoder
//             loopback and randomized symbol streams against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmds_decoder;

  localparam int LOCK_COUNT = 8;
  localparam int DISP_LIMIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] enc = 10'h354;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       blank;
  logic       locked;
  logic       err;

  always #5 clk = ~clk;

  tmds_decoder #(.LOCK_COUNT(LOCK_COUNT), .DISP_LIMIT(DISP_LIMIT)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_encoded       (enc),
    .o_data          (data),
    .o_control_data  (ctrl),
    .o_blanking      (blank),
    .o_locked        (locked),
    .o_err_disparity (err)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       blank;
    logic       locked;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------ reference model
  int         m_run    = 0;
  bit         m_locked = 0;
  int         m_acc    = 0;
  logic [7:0] m_data   = '0;
  logic [1:0] m_ctrl   = '0;
  int         enc_cnt  = 0;

  logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic int tok_code(input logic [9:0] q);
    for (int i = 0; i < 4; i++) if (toks[i] == q) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] b;
    d = q[9] ? ~q[7:0] : q[7:0];
    b[0] = d[0];
    for (int i = 1; i < 8; i++) b[i] = d[i] ^ d[i-1] ^ ~q[8];
    return b;
  endfunction

  task automatic model_reset();
    m_run = 0; m_locked = 0; m_acc = 0; m_data = '0; m_ctrl = '0; enc_cnt = 0;
  endtask

  task automatic model_step(input logic [9:0] q, input bit use_ref,
                            input logic [7:0] rb, output exp_t e);
    int code;
    bit viol;
    code = tok_code(q);
    viol = 0;
    if (code >= 0) begin
      m_ctrl = code[1:0];
      m_run++;
      if (m_run >= LOCK_COUNT) m_locked = 1;
      m_acc   = 0;
      enc_cnt = 0;
      e.blank = 1'b1;
    end else begin
      m_data = use_ref ? rb : ref_decode(q);
      m_run  = 0;
`ifdef TMDS_DEC_DISP_CHECK_EN
      m_acc += 2 * $countones(q) - 10;
      if (m_acc > DISP_LIMIT || m_acc < -DISP_LIMIT) begin
        viol     = 1;
        m_acc    = 0;
        m_locked = 0;
      end
`endif
      e.blank = 1'b0;
    end
    e.data   = m_data;
    e.ctrl   = m_ctrl;
    e.locked = m_locked;
    e.err    = viol;
  endtask

  // ------------------------------------------------------------- drivers
  task automatic send(input logic [9:0] q, input bit use_ref = 0,
                      input logic [7:0] rb = 8'h00);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    enc = q;
    model_step(q, use_ref, rb, e);
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      rst = 1'b1;
      enc = 10'($urandom);
      while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
      model_reset();
      e.due = cyc + 1; e.data = 8'h00; e.ctrl = 2'b00;
      e.blank = 1'b1; e.locked = 1'b0; e.err = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Standard DVI transmit encoder feeding the decoder in loopback.
  task automatic enc_send(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1, n0;
    bit use_xnor;
    n1d = $countones(d);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (enc_cnt == 0 || n1 == n0) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + (n1 - n0);
    end
    send(q, 1'b1, d);
  endtask

  // -------------------------------------------------------------- monitor
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // Pop and compare every expectation that falls due this cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("data",    data,               e.data);
        chk("control", {6'b0, ctrl},       {6'b0, e.ctrl});
        chk("blanking",{7'b0, blank},      {7'b0, e.blank});
        chk("locked",  {7'b0, locked},     {7'b0, e.locked});
        chk("err_disp",{7'b0, err},        {7'b0, e.err});
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  initial begin : stim
    int r;
    reset_cycles(4);

    // Lock on a constant token stream.
    repeat (12) send(10'h354);

    // Each token once.
    for (int i = 0; i < 4; i++) send(toks[i]);

    // Encoder loopback, alternating 0x00 / 0xFF.
    for (int i = 0; i < 30; i++) enc_send((i % 2) ? 8'hFF : 8'h00);

    // Disparity overrun while locked.
    repeat (8) send(10'h354);
    repeat (2) send(10'h3FF);
    repeat (3) send(10'h354);

    // Relock and reset mid-stream; broken run of seven then full run.
    repeat (10) send(10'h0AB);
    reset_cycles(1);
    repeat (7) send(10'h154);
    send(10'h1F0);
    repeat (8) send(10'h2AB);
    repeat (2) send(10'h3FF);

    // Randomized stream.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset_cycles(1);
      end else if (r < 8) begin
        repeat (LOCK_COUNT - 2 + $urandom_range(0, 4)) send(toks[$urandom_range(0, 3)]);
      end else if (r < 40) begin
        send(toks[$urandom_range(0, 3)]);
      end else if (r < 50) begin
        send((r % 2) ? 10'h3FF : 10'h000);
      end else if (r < 60) begin
        enc_send(8'($urandom));
      end else begin
        send(10'($urandom));
      end
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
